updown_count_sched: RTL and testbench

//  Shared up/down count engine with a two-requester round-robin scheduler.

---
 rtl/updown_count_sched.sv | 127 ++++++++++++
 tb/tb_updown_count_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_sched.sv
// Shared up/down count engine with a two-requester round-robin scheduler.
// Optional `PAUSE_EN adds a pause input that freezes stepping in RUN.
module updown_count_sched #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
`ifdef PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] Q
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESET, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic             own;
    logic             dn;
    logic [WIDTH-1:0] tgt;
  } run_t;

  state_t          state, state_n;
  run_t            run, run_n;
  logic            ptr, ptr_n;
  logic [PW-1:0]   psc, psc_n;
  logic [WIDTH-1:0] q_n;
  logic [1:0]      gnt_n, done_n;
  logic            busy_n;
  logic            sel;
  logic            stall;

`ifdef PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_n = state;
    run_n   = run;
    ptr_n   = ptr;
    psc_n   = psc;
    q_n     = Q;
    gnt_n   = gnt;
    done_n  = 2'b00;
    sel     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          // both high -> pointer decides; otherwise the lone requester wins
          sel     = (req == 2'b11) ? ptr : req[1];
          run_n   = '{own: sel, dn: dir[sel], tgt: (sel ? target1 : target0)};
          gnt_n   = sel ? 2'b10 : 2'b01;
          ptr_n   = ~sel;
          state_n = S_PRESET;
        end
      end
      S_PRESET: begin
        if (!req[run.own]) begin
          gnt_n   = 2'b00;
          state_n = S_IDLE;
        end else begin
          q_n     = run.dn ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          psc_n   = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // owner abort takes priority over completion
        if (!req[run.own]) begin
          gnt_n   = 2'b00;
          state_n = S_IDLE;
        end else if (Q == run.tgt) begin
          done_n  = gnt;
          state_n = S_DONE;
        end else if (!stall) begin
          if (psc == PS_LAST) begin
            q_n   = run.dn ? Q - 1'b1 : Q + 1'b1;
            psc_n = '0;
          end else begin
            psc_n = psc + 1'b1;
          end
        end
      end
      S_DONE: begin
        gnt_n   = 2'b00;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      run   <= '0;
      ptr   <= 1'b0;
      psc   <= '0;
      Q     <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      run   <= run_n;
      ptr   <= ptr_n;
      psc   <= psc_n;
      Q     <= q_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_updown_count_sched.sv
// Bench for updown_count_sched: two instances (PRESCALE 1 and 3) driven by the same
// directed and random stimulus, each checked against a run-level arithmetic model.
module tb_updown_count_sched;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;
  localparam int PS [2] = '{1, 3};

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req, dir;
  logic [W-1:0] target0, target1;
`ifdef PAUSE_EN
  logic         pause;
`endif
  logic [1:0]   gnt_o  [2];
  logic [1:0]   done_o [2];
  logic         busy_o [2];
  logic [W-1:0] q_o    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_count_sched #(.WIDTH(W), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .target0(target0), .target1(target1),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .gnt(gnt_o[0]), .done(done_o[0]), .busy(busy_o[0]), .Q(q_o[0]));

  updown_count_sched #(.WIDTH(W), .PRESCALE(3)) u1 (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .target0(target0), .target1(target1),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .gnt(gnt_o[1]), .done(done_o[1]), .busy(busy_o[1]), .Q(q_o[1]));

  // Run-level model: Q during a run is start + sign*floor(active_cycles/PRESCALE)
  bit m_pend [2];
  bit m_run  [2];
  bit m_dp   [2];
  int m_own  [2];
  int m_ptr  [2];
  int m_start[2];
  int m_sg   [2];
  int m_tgt  [2];
  int m_t    [2];
  int m_q    [2];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_run[k] = 0; m_dp[k] = 0; m_own[k] = 0; m_ptr[k] = 0;
      m_start[k] = 0; m_sg[k] = 1; m_tgt[k] = 0; m_t[k] = 0; m_q[k] = 0;
    end
  endtask

  task automatic mstep(input int k);
    bit pv;
    int i;
`ifdef PAUSE_EN
    pv = pause;
`else
    pv = 1'b0;
`endif
    if (m_dp[k]) begin
      m_dp[k] = 0;
    end else if (m_pend[k]) begin
      m_pend[k] = 0;
      if (req[m_own[k]]) begin
        m_run[k] = 1; m_q[k] = m_start[k]; m_t[k] = 0;
      end
    end else if (m_run[k]) begin
      if (!req[m_own[k]]) m_run[k] = 0;
      else if (m_q[k] == m_tgt[k]) begin
        m_run[k] = 0; m_dp[k] = 1;
      end else if (!pv) begin
        m_t[k]++;
        m_q[k] = m_start[k] + m_sg[k] * (m_t[k] / PS[k]);
      end
    end else if (req != 2'b00) begin
      i = (req == 2'b11) ? m_ptr[k] : (req[1] ? 1 : 0);
      m_own[k]   = i;
      m_start[k] = dir[i] ? MAX : 0;
      m_sg[k]    = dir[i] ? -1 : 1;
      m_tgt[k]   = (i == 1) ? int'(target1) : int'(target0);
      m_pend[k]  = 1;
      m_ptr[k]   = 1 - i;
    end
  endtask

  task automatic check_all();
    int act, eg;
    for (int k = 0; k < 2; k++) begin
      act = (m_pend[k] || m_run[k] || m_dp[k]) ? 1 : 0;
      eg  = act ? (m_own[k] ? 2 : 1) : 0;
      chk($sformatf("gnt%0d", k),  int'(gnt_o[k]),  eg);
      chk($sformatf("done%0d", k), int'(done_o[k]), m_dp[k] ? eg : 0);
      chk($sformatf("busy%0d", k), int'(busy_o[k]), act);
      chk($sformatf("q%0d", k),    int'(q_o[k]),    m_q[k]);
    end
  endtask

  // one clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst) mreset();
    else for (int k = 0; k < 2; k++) mstep(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input logic [1:0] r);
    rst = 1'b1;
    req = r;
    #1;
    mreset();
    chk("rst_q", int'(q_o[0]), 0);
    chk("rst_gnt", int'(gnt_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  int grants[$];
  logic [1:0] prevg, lastg;
  int guard;

  initial begin
    rst = 1'b1; req = 2'b00; dir = 2'b00; target0 = '0; target1 = '0;
`ifdef PAUSE_EN
    pause = 1'b0;
`endif
    mreset();
    @(negedge clk);
    do_reset(2'b00);

    // up run to 5
    req = 2'b01; dir = 2'b00; target0 = 4'd5;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 1) chk("t2_gnt", int'(gnt_o[0]), 1);
      if (e == 2) chk("t2_q0", int'(q_o[0]), 0);
      if (e == 7) chk("t2_q5", int'(q_o[0]), 5);
      if (e == 8) begin chk("t2_done", int'(done_o[0]), 1); req = 2'b00; end
      if (e == 9) begin chk("t2_busy", int'(busy_o[0]), 0); chk("t2_done_clr", int'(done_o[0]), 0); end
    end
    repeat (3) tick();

    // down run 15..12, then a zero-step run
    req = 2'b10; dir = 2'b10; target1 = 4'd12;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) chk("t3_gnt", int'(gnt_o[0]), 2);
      if (e == 2) chk("t3_q15", int'(q_o[0]), 15);
      if (e == 5) chk("t3_q12", int'(q_o[0]), 12);
      if (e == 6) begin chk("t3_done", int'(done_o[0]), 2); req = 2'b00; end
    end
    repeat (3) tick();
    req = 2'b10; target1 = 4'd15;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e == 3) begin chk("t3_zero_done", int'(done_o[0]), 2); req = 2'b00; end
    end
    repeat (3) tick();

`ifdef PAUSE_EN
    // pause at Q=2 for four cycles delays done by four
    req = 2'b01; dir = 2'b00; target0 = 4'd5;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 4) begin chk("t6_q2", int'(q_o[0]), 2); pause = 1'b1; end
      if (e == 8) begin chk("t6_q_frozen", int'(q_o[0]), 2); pause = 1'b0; end
      if (e == 11) chk("t6_no_early_done", int'(done_o[0]), 0);
      if (e == 12) begin chk("t6_done", int'(done_o[0]), 1); req = 2'b00; end
    end
    repeat (3) tick();
`endif

    // both requesters held from reset: 01,10,01
    dir = 2'b00; target0 = 4'd3; target1 = 4'd2;
    do_reset(2'b11);
    prevg = 2'b00; lastg = 2'b00; guard = 0;
    while (grants.size() < 3 && guard < 60) begin
      tick();
      guard++;
      if (gnt_o[0] != 2'b00 && prevg == 2'b00) begin grants.push_back(int'(gnt_o[0])); lastg = gnt_o[0]; end
      if (done_o[0] != 2'b00) chk("t4_done_owner", int'(done_o[0]), int'(lastg));
      prevg = gnt_o[0];
    end
    chk("t4_ngrants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("t4_g0", grants[0], 1);
      chk("t4_g1", grants[1], 2);
      chk("t4_g2", grants[2], 1);
    end

    // abort at Q=3 with req1 pending
    dir = 2'b00; target0 = 4'd9; target1 = 4'd4;
    do_reset(2'b00);
    req = 2'b11;
    guard = 0;
    while (q_o[0] != 4'd3 && guard < 20) begin tick(); guard++; end
    chk("t5_reach3", int'(q_o[0]), 3);
    req = 2'b10;
    tick();
    chk("t5_gnt_off", int'(gnt_o[0]), 0);
    chk("t5_q_hold", int'(q_o[0]), 3);
    chk("t5_no_done", int'(done_o[0]), 0);
    tick();
    chk("t5_gnt1", int'(gnt_o[0]), 2);
    req = 2'b00;
    repeat (3) tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2'b00);
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (done_o[0][i]) begin
            if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
          end else if (!req[i]) begin
            if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
          end else if ($urandom_range(0, 59) == 0) begin
            req[i] = 1'b0;
          end
          if ($urandom_range(0, 4) == 0) dir[i] = 1'($urandom);
        end
        if ($urandom_range(0, 4) == 0) target0 = W'($urandom);
        if ($urandom_range(0, 4) == 0) target1 = W'($urandom);
`ifdef PAUSE_EN
        pause = ($urandom_range(0, 4) == 0);
`endif
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
